// File: rtl/bias_sched_pkg.sv
// Shared types and constants for the bias-add scheduler: FSM states, default lane
// width, saturation limits and the lane bit-offset helper.
package bias_sched_pkg;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam int unsigned DATA_W_DEFAULT = 18;

  localparam logic [DATA_W_DEFAULT-1:0] SAT_MAX = 18'h1FFFF;
  localparam logic [DATA_W_DEFAULT-1:0] SAT_MIN = 18'h20000;

  // LSB position of lane 'lane' in a flat vector of 'width'-bit lanes.
  function automatic int unsigned lane_lsb(input int unsigned width, input int unsigned lane);
    return width * lane;
  endfunction

endpackage

// File: rtl/bias_add_scheduler_if.sv
// Valid/ready beat stream carrying N_adder_tree packed DATA_W-bit lanes.
interface bias_add_scheduler_if #(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned DATA_W       = 18
);
  logic                           valid;
  logic                           ready;
  logic [N_adder_tree*DATA_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/bias_lane_sat.sv
// One lane: signed add of data and bias with saturation to DATA_W bits.
// Optional fused ReLU when BIAS_ADD_RELU_EN is defined.
module bias_lane_sat
  import bias_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEFAULT
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic [DATA_W-1:0] i_bias,
  output logic [DATA_W-1:0] o_sum
);

  logic [DATA_W:0]   w_sum;
  logic [DATA_W-1:0] w_sat;

  assign w_sum = {i_data[DATA_W-1], i_data} + {i_bias[DATA_W-1], i_bias};

  // Overflow iff the two top bits of the widened sum disagree; the top bit gives the sign.
  always_comb begin
    w_sat = w_sum[DATA_W-1:0];
    if (w_sum[DATA_W] != w_sum[DATA_W-1]) begin
      w_sat = w_sum[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    end
  end

`ifdef BIAS_ADD_RELU_EN
  assign o_sum = w_sat[DATA_W-1] ? '0 : w_sat;
`else
  assign o_sum = w_sat;
`endif

endmodule

// File: rtl/bias_add_scheduler.sv
// Per-bank bias add after the conv adder tree: one pass per start, cfg_pixels beats per
// bank, saturated results through a valid/ready register. BIAS_ADD_RELU_EN fuses a ReLU.
module bias_add_scheduler
  import bias_sched_pkg::*;
#(
  parameter int unsigned N_adder_tree = 16,
  parameter int unsigned DATA_W       = DATA_W_DEFAULT,
  parameter int unsigned N_GROUPS     = 2,
  parameter int unsigned CNT_W        = 16,
  localparam int unsigned BANK_W      = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   i_start,
  input  logic [CNT_W-1:0]                       i_cfg_pixels,
  input  logic [N_GROUPS*N_adder_tree*DATA_W-1:0] i_bias_in,
  bias_add_scheduler_if.slave                    s_in,
  bias_add_scheduler_if.master                   m_out,
  output logic [BANK_W-1:0]                      o_bank_sel,
  output logic                                   o_busy,
  output logic                                   o_done
);

  state_e                         r_state, w_state_nxt;
  logic [CNT_W-1:0]               r_cfg, w_cfg_nxt;
  logic [CNT_W-1:0]               r_pix_cnt, w_pix_nxt;
  logic [BANK_W-1:0]              r_bank, w_bank_nxt;
  logic                           r_out_valid;
  logic [N_adder_tree*DATA_W-1:0] r_out_data;
  logic [N_adder_tree*DATA_W-1:0] w_sum;
  logic                           w_in_ready;
  logic                           w_accept;
  logic                           w_last;

  assign w_in_ready = (r_state == StRun) && (!r_out_valid || m_out.ready);
  assign w_accept   = s_in.valid && w_in_ready;
  assign w_last     = (r_pix_cnt == r_cfg - CNT_W'(1));

  for (genvar g_i = 0; g_i < N_adder_tree; g_i++) begin : g_lane
    logic [DATA_W-1:0] w_bias;
    assign w_bias = i_bias_in[lane_lsb(DATA_W, N_adder_tree * 32'(r_bank) + g_i) +: DATA_W];
    bias_lane_sat #(.DATA_W(DATA_W)) u_sat (
      .i_data (s_in.data[g_i*DATA_W +: DATA_W]),
      .i_bias (w_bias),
      .o_sum  (w_sum[g_i*DATA_W +: DATA_W])
    );
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cfg_nxt   = r_cfg;
    w_pix_nxt   = r_pix_cnt;
    w_bank_nxt  = r_bank;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_cfg_nxt   = i_cfg_pixels;
          w_pix_nxt   = '0;
          w_bank_nxt  = '0;
          w_state_nxt = (i_cfg_pixels == '0) ? StDone : StRun;
        end
      end
      StRun: begin
        if (w_accept) begin
          if (w_last) begin
            w_pix_nxt = '0;
            if (r_bank < BANK_W'(N_GROUPS - 1)) w_bank_nxt = r_bank + BANK_W'(1);
            else                                w_state_nxt = StDrain;
          end else begin
            w_pix_nxt = r_pix_cnt + CNT_W'(1);
          end
        end
      end
      StDrain: begin
        if (!r_out_valid || m_out.ready) w_state_nxt = StDone;
      end
      StDone: begin
        w_bank_nxt  = '0;
        w_state_nxt = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_cfg     <= '0;
      r_pix_cnt <= '0;
      r_bank    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cfg     <= w_cfg_nxt;
      r_pix_cnt <= w_pix_nxt;
      r_bank    <= w_bank_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sum;
    end else if (m_out.ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign s_in.ready  = w_in_ready;
  assign m_out.valid = r_out_valid;
  assign m_out.data  = r_out_data;
  assign o_bank_sel  = r_bank;
  assign o_busy      = (r_state != StIdle);
  assign o_done      = (r_state == StDone);

endmodule

// File: tb/tb_bias_add_scheduler.sv
// Randomised self-checking bench for bias_add_scheduler against a lane-arithmetic model.
module tb_bias_add_scheduler;
  import bias_sched_pkg::*;

  localparam int N = 16;
  localparam int W = 18;
  localparam int G = 2;
  localparam int C = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [C-1:0]     cfg = '0;
  logic [G*N*W-1:0] bias = '0;
  logic [0:0]       bank_sel;
  logic             busy;
  logic             done;

  bias_add_scheduler_if #(.N_adder_tree(N), .DATA_W(W)) in_if ();
  bias_add_scheduler_if #(.N_adder_tree(N), .DATA_W(W)) out_if ();

  bias_add_scheduler #(.N_adder_tree(N), .DATA_W(W), .N_GROUPS(G), .CNT_W(C)) dut (
    .clk          (clk),
    .rst          (rst),
    .i_start      (start),
    .i_cfg_pixels (cfg),
    .i_bias_in    (bias),
    .s_in         (in_if.slave),
    .m_out        (out_if.master),
    .o_bank_sel   (bank_sel),
    .o_busy       (busy),
    .o_done       (done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  logic [N*W-1:0] outs[$];
  logic [N*W-1:0] fixed_data;

  // Reference: each lane is clamp(data + bias[bank][lane]) in plain integer arithmetic.
  function automatic logic [N*W-1:0] model(input logic [N*W-1:0] d, input int bank);
    logic [N*W-1:0] r;
    int s;
    int hi = int'($signed(SAT_MAX));
    int lo = int'($signed(SAT_MIN));
    for (int i = 0; i < N; i++) begin
      s = int'($signed(d[W*i +: W])) + int'($signed(bias[W*(bank*N+i) +: W]));
      if (s > hi) s = hi;
      if (s < lo) s = lo;
`ifdef BIAS_ADD_RELU_EN
      if (s < 0) s = 0;
`endif
      r[W*i +: W] = W'(s);
    end
    return r;
  endfunction

  function automatic logic [N*W-1:0] rand_vec();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) begin
      case ($urandom_range(0, 3))
        0:       v[W*i +: W] = 18'h1FF00 + W'($urandom_range(0, 255));
        1:       v[W*i +: W] = 18'h20000 + W'($urandom_range(0, 255));
        default: v[W*i +: W] = W'($urandom);
      endcase
    end
    return v;
  endfunction

  task automatic rand_bias();
    for (int i = 0; i < G*N; i++) bias[W*i +: W] = W'($urandom);
  endtask

  // One pass; stall_at forces out_ready low for 4 cycles, restart_at pulses a stray start.
  task automatic run_pass(input int cfg_v, input int vpct, input int rpct, input int stall_at,
                          input int restart_at, input bit fixed);
    logic [N*W-1:0] exp_q[$];
    logic [N*W-1:0] prev_data;
    logic [N*W-1:0] e;
    int  sent = 0, got = 0, cyc = 0;
    bit  hold_v = 0, prev_stall = 0, fin = 0;
    outs.delete();
    @(posedge clk); #1;
    start = 1'b1; cfg = C'(cfg_v); in_if.valid = 1'b0; out_if.ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; cfg = C'($urandom);
    while (!fin && cyc < 3000) begin
      if (cyc == restart_at) begin start = 1'b1; cfg = C'(cfg_v + 2); end
      else start = 1'b0;
      if (!hold_v) begin
        in_if.valid = ($urandom_range(0, 99) < vpct);
        in_if.data  = fixed ? fixed_data : rand_vec();
      end
      if (stall_at >= 0 && cyc >= stall_at && cyc < stall_at + 4) out_if.ready = 1'b0;
      else out_if.ready = ($urandom_range(0, 99) < rpct);
      @(negedge clk);
      n_cmp++;
      if (busy !== 1'b1) begin
        n_fail++; $display("FAIL busy_in_pass: got %b want 1 (cyc %0d)", busy, cyc);
      end
      if (prev_stall && out_if.valid) begin
        n_cmp++;
        if (out_if.data !== prev_data) begin
          n_fail++; $display("FAIL hold_data: got %h want %h", out_if.data, prev_data);
        end
      end
      if (out_if.valid && !out_if.ready) begin
        n_cmp++;
        if (in_if.ready !== 1'b0) begin
          n_fail++; $display("FAIL bp_in_ready: got %b want 0", in_if.ready);
        end
      end
      if (out_if.valid && out_if.ready) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL extra_out: got %h want none", out_if.data);
        end else begin
          e = exp_q.pop_front();
          if (out_if.data !== e) begin
            n_fail++; $display("FAIL out_data[%0d]: got %h want %h", got, out_if.data, e);
          end
        end
        outs.push_back(out_if.data);
        got++;
      end
      if (in_if.valid && in_if.ready) begin
        n_cmp++;
        if (bank_sel !== 1'(sent / cfg_v)) begin
          n_fail++; $display("FAIL bank_sel[%0d]: got %0d want %0d", sent, bank_sel, sent / cfg_v);
        end
        exp_q.push_back(model(in_if.data, sent / cfg_v));
        sent++;
        hold_v = 1'b0;
      end else begin
        hold_v = in_if.valid;
      end
      prev_stall = out_if.valid && !out_if.ready;
      prev_data  = out_if.data;
      if (done) fin = 1'b1;
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0; in_if.valid = 1'b0; out_if.ready = 1'b1;
    n_cmp++;
    if (!fin) begin n_fail++; $display("FAIL pass_timeout: got no done want done"); end
    n_cmp++;
    if (sent != G*cfg_v) begin
      n_fail++; $display("FAIL beats_in: got %0d want %0d", sent, G*cfg_v);
    end
    n_cmp++;
    if (got != G*cfg_v || exp_q.size() != 0) begin
      n_fail++; $display("FAIL beats_out: got %0d want %0d", got, G*cfg_v);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0 || bank_sel !== 1'b0 || out_if.valid !== 1'b0) begin
      n_fail++;
      $display("FAIL post_pass: got done=%b busy=%b bank=%0d ov=%b want 0 0 0 0",
               done, busy, bank_sel, out_if.valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (out_if.valid !== 1'b0 || in_if.ready !== 1'b0 || busy !== 1'b0 || done !== 1'b0 ||
        bank_sel !== 1'b0 || out_if.data !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got ov=%b ir=%b busy=%b done=%b bank=%0d od=%h want all 0",
               out_if.valid, in_if.ready, busy, done, bank_sel, out_if.data);
    end
  endtask

  task automatic test_basic();
    bias = '0;
    bias[W*0 +: W]     = 18'h02BEC;
    bias[W*(N) +: W]   = 18'h3EEE8;
    fixed_data         = '0;
    fixed_data[W-1:0]  = 18'h00010;
    run_pass(3, 100, 100, -1, -1, 1'b1);
    n_cmp++;
    if (outs.size() != 6) begin
      n_fail++; $display("FAIL basic_count: got %0d want 6", outs.size());
    end else begin
      n_cmp++;
      if (outs[0][W-1:0] !== 18'h02BFC || outs[2][W-1:0] !== 18'h02BFC) begin
        n_fail++; $display("FAIL basic_bank0: got %h want 02bfc", outs[0][W-1:0]);
      end
      n_cmp++;
      if (outs[3][W-1:0] !== 18'h3EEF8 || outs[5][W-1:0] !== 18'h3EEF8) begin
        n_fail++; $display("FAIL basic_bank1: got %h want 3eef8", outs[3][W-1:0]);
      end
    end
  endtask

  task automatic test_saturation();
    logic [W-1:0] want_neg;
`ifdef BIAS_ADD_RELU_EN
    want_neg = 18'h00000;
`else
    want_neg = 18'h20000;
`endif
    bias = '0;
    for (int g = 0; g < G; g++) begin
      bias[W*(g*N+0) +: W] = 18'h00200;
      bias[W*(g*N+1) +: W] = 18'h3FF00;
    end
    fixed_data = '0;
    fixed_data[W*0 +: W] = 18'h1FF00;
    fixed_data[W*1 +: W] = 18'h20010;
    run_pass(1, 100, 100, -1, -1, 1'b1);
    n_cmp++;
    if (outs.size() != 2) begin
      n_fail++; $display("FAIL sat_count: got %0d want 2", outs.size());
    end else begin
      n_cmp++;
      if (outs[0][W*0 +: W] !== 18'h1FFFF) begin
        n_fail++; $display("FAIL sat_pos: got %h want 1ffff", outs[0][W*0 +: W]);
      end
      n_cmp++;
      if (outs[1][W*1 +: W] !== want_neg) begin
        n_fail++; $display("FAIL sat_neg: got %h want %h", outs[1][W*1 +: W], want_neg);
      end
    end
  endtask

  task automatic test_backpressure();
    rand_bias();
    run_pass(4, 100, 100, 3, -1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      rand_bias();
      run_pass($urandom_range(1, 6), 75, 60, -1, -1, 1'b0);
    end
  endtask

  task automatic test_zero_length();
    @(posedge clk); #1; start = 1'b1; cfg = '0;
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || done !== 1'b1 || out_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_done: got busy=%b done=%b ov=%b want 1 1 0",
                         busy, done, out_if.valid);
    end
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || done !== 1'b0 || out_if.valid !== 1'b0) begin
      n_fail++; $display("FAIL zero_idle: got busy=%b done=%b ov=%b want 0 0 0",
                         busy, done, out_if.valid);
    end
  endtask

  task automatic test_reset_mid();
    int acc = 0, cyc = 0;
    rand_bias();
    @(posedge clk); #1; start = 1'b1; cfg = C'(3); in_if.valid = 1'b1; out_if.ready = 1'b1;
    in_if.data = rand_vec();
    @(posedge clk); #1; start = 1'b0;
    while (acc < 2 && cyc < 50) begin
      @(negedge clk);
      if (in_if.valid && in_if.ready) acc++;
      @(posedge clk); #1;
      in_if.data = rand_vec();
      cyc++;
    end
    rst = 1'b1;
    #1;
    n_cmp++;
    if (acc != 2 || out_if.valid !== 1'b0 || bank_sel !== 1'b0 || busy !== 1'b0 ||
        in_if.ready !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid: got acc=%0d ov=%b bank=%0d busy=%b want 2 0 0 0",
                         acc, out_if.valid, bank_sel, busy);
    end
    in_if.valid = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    rand_bias();
    run_pass(3, 100, 100, -1, -1, 1'b0);
  endtask

  task automatic test_ignored_start();
    rand_bias();
    run_pass(3, 100, 100, -1, 2, 1'b0);
    rand_bias();
    run_pass(2, 60, 80, -1, 1, 1'b0);
  endtask

  initial begin
    in_if.valid = 1'b0;
    in_if.data  = '0;
    out_if.ready = 1'b1;
    fixed_data = '0;
    repeat (3) @(posedge clk);
    test_reset();
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_saturation();
    test_backpressure();
    test_zero_length();
    test_reset_mid();
    test_ignored_start();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
